reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits (legal 1..64).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of 2, 2..256); AW = log2(DEPTH).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RES  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port WE  input  1  write request.
REQ-006 SHALL have port WADDR  input  AW  write address.
REQ-007 SHALL have port WDATA  input  WIDTH  write data.
REQ-008 SHALL have port RADDR_A  input  AW  read port A address.
REQ-009 SHALL have port RADDR_B  input  AW  read port B address.
REQ-010 SHALL have port RDATA_A  output  WIDTH  port A registered read data.
REQ-011 SHALL have port RDATA_B  output  WIDTH  port B registered read data.
REQ-012 SHALL have port CLR  input  1  soft-clear request, single-cycle pulse.
REQ-013 SHALL have port BUSY  output  1  soft-clear sweep in progress.
REQ-014 SHALL have port WR_ACK  output  1  registered; high the cycle after a write is accepted.

Function
REQ-015 Write: WE=1, BUSY=0 at a rising edge SHALL store WDATA into entry WADDR; WR_ACK=1 on the next cycle.
REQ-016 Write with BUSY=1 SHALL be dropped; WR_ACK=0 next cycle.
REQ-017 Reads SHALL have 1-cycle latency: RDATA_x after edge N = entry RADDR_x sampled at edge N.
REQ-018 Both read ports SHALL be independent; equal addresses return identical data.
REQ-019 Same-edge write and read of one address: behaviour per REQ-029/REQ-030.
REQ-020 FSM states IDLE, SWEEP. IDLE->SWEEP on CLR=1; a sweep counter loads 0, BUSY=1 from the next cycle.
REQ-021 SWEEP SHALL zero entry[counter] each cycle, counter+1; after entry DEPTH-1 is cleared -> IDLE, BUSY=0 the next cycle (DEPTH cycles total with BUSY=1).
REQ-022 CLR during SWEEP SHALL be ignored (no restart).
REQ-023 CLR and WE on the same edge in IDLE: write SHALL be accepted, then overwritten by the sweep.
REQ-024 Reads during SWEEP SHALL stay enabled and return current contents (cleared entries read 0).
REQ-025 WR_ACK SHALL be 0 whenever no write was accepted on the previous edge.

Reset
REQ-026 RES=0 at a rising edge SHALL zero all entries, RDATA_A, RDATA_B, WR_ACK, BUSY, sweep counter; FSM -> IDLE.
REQ-027 RES=0 mid-sweep SHALL abort the sweep; reset dominates WE and CLR.
REQ-028 First write SHALL be accepted at the first edge with RES=1.

Configuration
REQ-029 With REG_FILE_BYPASS_EN defined: same-edge accepted write to RADDR_x SHALL forward WDATA to RDATA_x (write-before-read).
REQ-030 Without REG_FILE_BYPASS_EN: RDATA_x SHALL return the entry's old value in that case (read-before-write); no bypass logic.

Verification
REQ-031 Reset then read addr 0..DEPTH-1 on both ports -> all 0, BUSY=0, WR_ACK=0.
REQ-032 Write 0xBEEF @3, then RADDR_A=3, RADDR_B=3 -> both ports 0xBEEF one cycle later; WR_ACK=1 the cycle after the write.
REQ-033 WE=1 WADDR=5 WDATA=0x1234, RADDR_A=5 same edge; prior content 0x0 -> RDATA_A=0x1234 with macro, 0x0000 without.
REQ-034 Fill all entries with 0xA5A5, pulse CLR -> BUSY high exactly DEPTH cycles; write during BUSY gets WR_ACK=0 and is lost; afterwards all reads 0.
REQ-035 Pulse CLR, drive RES=0 at cycle 4 of the sweep -> next cycle BUSY=0, all outputs 0; write 0x0F0F @7 accepted next edge after RES=1.
REQ-036 WIDTH=8, DEPTH=4: write 0xFF @3, read @3 -> 0xFF; address wrap not possible (AW=2).

Source files
------------

// File: rtl/reg_file.sv
// reg_file: 1-write / 2-read register file with registered reads and a soft-clear sweep FSM.
// Optional macro REG_FILE_BYPASS_EN forwards same-edge write data to matching read ports.
module reg_file #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     RES,
    input  logic                     WE,
    input  logic [$clog2(DEPTH)-1:0] WADDR,
    input  logic [WIDTH-1:0]         WDATA,
    input  logic [$clog2(DEPTH)-1:0] RADDR_A,
    input  logic [$clog2(DEPTH)-1:0] RADDR_B,
    output logic [WIDTH-1:0]         RDATA_A,
    output logic [WIDTH-1:0]         RDATA_B,
    input  logic                     CLR,
    output logic                     BUSY,
    output logic                     WR_ACK
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0]  rdata_b_q, rdata_b_d;
    logic              wr_ack_q;
    logic              wr_acc;
    logic              sweep_clr;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_acc    = WE && (state_q == IDLE);
        sweep_clr = (state_q == SWEEP);
        rdata_a_d = mem_q[RADDR_A];
        rdata_b_d = mem_q[RADDR_B];

        unique case (state_q)
            IDLE: begin
                if (CLR) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef REG_FILE_BYPASS_EN
        if (wr_acc && (WADDR == RADDR_A)) rdata_a_d = WDATA;
        if (wr_acc && (WADDR == RADDR_B)) rdata_b_d = WDATA;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK) begin
        if (!RES) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            wr_ack_q  <= 1'b0;
            // NOTE: the storage array is reset too, so this cannot map onto a plain RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            wr_ack_q  <= wr_acc;
            // A write and a sweep never coincide: writes are only accepted in IDLE.
            if (wr_acc) begin
                mem_q[WADDR] <= WDATA;
            end
            if (sweep_clr) begin
                mem_q[cnt_q] <= '0;
            end
        end
    end

    assign RDATA_A = rdata_a_q;
    assign RDATA_B = rdata_b_q;
    assign WR_ACK  = wr_ack_q;
    assign BUSY    = (state_q == SWEEP);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reference model feeds a scoreboard queue, popped after each edge.
// A second 8x4 instance covers the narrow configuration.
module tb_reg_file;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 16x16 instance
    logic        res, we, clr;
    logic [3:0]  waddr, raddr_a, raddr_b;
    logic [15:0] wdata;
    logic [15:0] rdata_a, rdata_b;
    logic        busy, wr_ack;

    reg_file #(.WIDTH(16), .DEPTH(16)) dut (
        .CLK(clk), .RES(res), .WE(we), .WADDR(waddr), .WDATA(wdata),
        .RADDR_A(raddr_a), .RADDR_B(raddr_b), .RDATA_A(rdata_a), .RDATA_B(rdata_b),
        .CLR(clr), .BUSY(busy), .WR_ACK(wr_ack)
    );

    // 8x4 instance
    logic        s_res, s_we, s_clr;
    logic [1:0]  s_waddr, s_raddr_a, s_raddr_b;
    logic [7:0]  s_wdata, s_rdata_a, s_rdata_b;
    logic        s_busy, s_wr_ack;

    reg_file #(.WIDTH(8), .DEPTH(4)) dut_s (
        .CLK(clk), .RES(s_res), .WE(s_we), .WADDR(s_waddr), .WDATA(s_wdata),
        .RADDR_A(s_raddr_a), .RADDR_B(s_raddr_b), .RDATA_A(s_rdata_a), .RDATA_B(s_rdata_b),
        .CLR(s_clr), .BUSY(s_busy), .WR_ACK(s_wr_ack)
    );

    typedef struct {
        logic [15:0] ra;
        logic [15:0] rb;
        logic        ack;
        logic        busy;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          busy_cnt = 0;

    logic [15:0] m_mem [16];
    logic        m_busy = 1'b0;
    int          m_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 16x16 instance, predict its outputs, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic w, input logic c,
                        input logic [3:0] wa, input logic [15:0] wd,
                        input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        exp_t got;
        logic acc;
        res = r; we = w; clr = c; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;

        if (!r) begin
            e = '{ra: 16'h0, rb: 16'h0, ack: 1'b0, busy: 1'b0};
            foreach (m_mem[i]) m_mem[i] = 16'h0;
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            acc   = w && !m_busy;
            e.ra  = m_mem[a];
            e.rb  = m_mem[b];
`ifdef REG_FILE_BYPASS_EN
            if (acc && wa == a) e.ra = wd;
            if (acc && wa == b) e.rb = wd;
`endif
            e.ack = acc;
            if (acc) m_mem[wa] = wd;
            if (m_busy) begin
                m_mem[m_cnt] = 16'h0;
                if (m_cnt == 15) m_busy = 1'b0;
                else m_cnt++;
            end else if (c) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
            e.busy = m_busy;
        end
        sb.push_back(e);

        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (busy) busy_cnt++;
        check({tag, ".rdata_a"}, 64'(rdata_a), 64'(got.ra));
        check({tag, ".rdata_b"}, 64'(rdata_b), 64'(got.rb));
        check({tag, ".wr_ack"},  64'(wr_ack),  64'(got.ack));
        check({tag, ".busy"},    64'(busy),    64'(got.busy));
    endtask

    task automatic s_step(input string tag, input logic r, input logic w,
                          input logic [1:0] wa, input logic [7:0] wd, input logic [1:0] a,
                          input logic [7:0] exp_ra, input logic exp_ack);
        s_res = r; s_we = w; s_waddr = wa; s_wdata = wd; s_raddr_a = a; s_raddr_b = a;
        @(posedge clk);
        #1;
        check({tag, ".rdata_a"}, 64'(s_rdata_a), 64'(exp_ra));
        check({tag, ".rdata_b"}, 64'(s_rdata_b), 64'(exp_ra));
        check({tag, ".wr_ack"},  64'(s_wr_ack),  64'(exp_ack));
    endtask

    initial begin
        res = 1'b0; we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        s_res = 1'b0; s_we = 1'b0; s_clr = 1'b0; s_waddr = '0; s_wdata = '0;
        s_raddr_a = '0; s_raddr_b = '0;

        // Reset, then every address reads zero on both ports
        step("rst0", 1'b0, 1'b1, 1'b1, 4'd1, 16'hFFFF, 4'd0, 4'd0);
        step("rst1", 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
        for (int i = 0; i < 16; i++)
            step("rd_zero", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i));

        // Basic write/read and dual-port equal-address read
        step("wr_beef", 1'b1, 1'b1, 1'b0, 4'd3, 16'hBEEF, 4'd0, 4'd1);
        step("rd_beef", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 4'd3);
        check("beef_const", 64'(rdata_a), 64'h0000_BEEF);

        // Same-edge write and read of one address
        step("wr_rd_5", 1'b1, 1'b1, 1'b0, 4'd5, 16'h1234, 4'd5, 4'd5);
        step("rd_5", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 4'd3);

        // Random writes with lagging reads
        for (int i = 0; i < 12; i++)
            step("rand", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 4'($urandom_range(0, 15)),
                 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        // Fill with A5A5, then soft-clear sweep with blocked write and a repeated CLR
        for (int i = 0; i < 16; i++)
            step("fill", 1'b1, 1'b1, 1'b0, 4'(i), 16'hA5A5, 4'(i), 4'((i + 15) % 16));
        busy_cnt = 0;
        step("clr", 1'b1, 1'b0, 1'b1, 4'd0, 16'h0, 4'd0, 4'd15);
        for (int i = 0; i < 20; i++) begin
            if (i == 3)
                step("wr_busy", 1'b1, 1'b1, 1'b0, 4'd14, 16'h7777, 4'd14, 4'd0);
            else if (i == 6)
                step("clr_busy", 1'b1, 1'b0, 1'b1, 4'd0, 16'h0, 4'd15, 4'd2);
            else
                step("sweep", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'(i % 16), 4'(15 - (i % 16)));
        end
        check("busy_cycles", 64'(busy_cnt), 64'd16);
        for (int i = 0; i < 16; i++)
            step("rd_cleared", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'(i), 4'(i));

        // CLR together with a write, reset on sweep cycle 4, then write right after reset
        step("pre_wr", 1'b1, 1'b1, 1'b0, 4'd9, 16'h5555, 4'd0, 4'd0);
        step("clr_we", 1'b1, 1'b1, 1'b1, 4'd2, 16'hCAFE, 4'd9, 4'd2);
        step("sw1", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd2, 4'd9);
        step("sw2", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd2);
        step("sw3", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd9, 4'd0);
        step("rst_mid", 1'b0, 1'b1, 1'b1, 4'd7, 16'h1111, 4'd9, 4'd9);
        step("wr_0f0f", 1'b1, 1'b1, 1'b0, 4'd7, 16'h0F0F, 4'd9, 4'd2);
        step("rd_0f0f", 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 4'd7, 4'd9);
        check("0f0f_const", 64'(rdata_a), 64'h0000_0F0F);

        // 8x4 instance
        s_step("s_rst", 1'b0, 1'b1, 2'd3, 8'hAA, 2'd3, 8'h00, 1'b0);
        s_step("s_wr", 1'b1, 1'b1, 2'd3, 8'hFF, 2'd0, 8'h00, 1'b1);
        s_step("s_rd3", 1'b1, 1'b0, 2'd0, 8'h00, 2'd3, 8'hFF, 1'b0);
        s_step("s_rd0", 1'b1, 1'b0, 2'd0, 8'h00, 2'd0, 8'h00, 1'b0);
        check("s_busy", 64'(s_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
